// File: rtl/mult_control.sv
// mult_control: sequencing FSM for the shift-add signed multiplier datapath.
// Issues one-hot clear/add/sub/shift pulses, subtracting on the last (sign) bit.
module mult_control #(
  parameter int N = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 ClearA_LoadB,
  input  logic                 M,
  output logic                 Clr_Ld,
  output logic                 Clr_XA,
  output logic                 Add,
  output logic                 Sub,
  output logic                 Shift,
  output logic                 Busy,
  output logic                 Done,
  output logic [$clog2(N)-1:0] Step
);
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] KLAST = KW'(N - 1);
  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HOLD} state_t;
  state_t state, state_n;
  logic [KW-1:0] k, k_n;
  logic last;
  assign last = k == KLAST;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
    end
  end
  always_comb begin
    state_n = state;
    k_n     = k;
    case (state)
      IDLE:  state_n = Run ? CLEAR : IDLE;
      CLEAR: begin
        state_n = ADD;
        k_n     = '0;
      end
      ADD:   state_n = SHIFT;
      SHIFT: begin
        state_n = last ? HOLD : ADD;
        k_n     = last ? k : k + KW'(1);
      end
      HOLD:  state_n = Run ? HOLD : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Reset gates every output so nothing reaches the datapath while it is held.
  always_comb begin
    Clr_Ld = ~Reset && state == IDLE && ClearA_LoadB && ~Run;
    Clr_XA = ~Reset && state == CLEAR;
    Add    = ~Reset && state == ADD && M && ~last;
    Sub    = ~Reset && state == ADD && M && last;
    Shift  = ~Reset && state == SHIFT;
    Busy   = ~Reset && (state == CLEAR || state == ADD || state == SHIFT);
    Done   = ~Reset && state == HOLD;
    Step   = (~Reset && (state == ADD || state == SHIFT)) ? k : '0;
  end
endmodule

// File: tb/tb_mult_control.sv
// tb_mult_control: table-driven check of mult_control for N=8 and N=4.
// Each row gives this cycle's inputs and the outputs expected before the next edge.
module tb_mult_control;
  localparam logic [6:0] CLR_LD = 7'b1000000, CLR_XA = 7'b0100000, ADD = 7'b0010000,
                         SUB = 7'b0001000, SHIFT = 7'b0000100, BUSY = 7'b0000010,
                         DONE = 7'b0000001;
  typedef struct {
    bit         sel;
    logic       rst, run, clb, m;
    logic [6:0] ctl;
    logic [2:0] step;
  } vec_t;
  vec_t tbl[$];
  bit cur_sel;
  int n_cmp = 0, n_bad = 0;
  logic clk = 0;
  logic rst8 = 1, run8 = 0, clb8 = 0, m8 = 0;
  logic rst4 = 1, run4 = 0, clb4 = 0, m4 = 0;
  logic clr_ld8, clr_xa8, add8, sub8, shift8, busy8, done8;
  logic clr_ld4, clr_xa4, add4, sub4, shift4, busy4, done4;
  logic [2:0] step8;
  logic [1:0] step4;
  always #5 clk = ~clk;
  mult_control #(.N(8)) dut8 (
    .Clk(clk), .Reset(rst8), .Run(run8), .ClearA_LoadB(clb8), .M(m8),
    .Clr_Ld(clr_ld8), .Clr_XA(clr_xa8), .Add(add8), .Sub(sub8), .Shift(shift8),
    .Busy(busy8), .Done(done8), .Step(step8)
  );
  mult_control #(.N(4)) dut4 (
    .Clk(clk), .Reset(rst4), .Run(run4), .ClearA_LoadB(clb4), .M(m4),
    .Clr_Ld(clr_ld4), .Clr_XA(clr_xa4), .Add(add4), .Sub(sub4), .Shift(shift4),
    .Busy(busy4), .Done(done4), .Step(step4)
  );
  task automatic push(input logic rst, run, clb, m, input logic [6:0] ctl, input int step);
    tbl.push_back('{cur_sel, rst, run, clb, m, ctl, 3'(step)});
  endtask
  // Rows for CLEAR through SHIFT(k): interval after edge j is CLEAR (j=0),
  // ADD(k) (j=1+2k) or SHIFT(k) (j=2+2k); M is 1 outside ADD to show it is ignored.
  task automatic gen_run(input int nn, input logic [7:0] b, input logic run, input int jmax);
    for (int j = 0; j < jmax; j++) begin
      if (j == 0) push(0, run, 1, 1, CLR_XA | BUSY, 0);
      else if (j % 2 == 1) begin
        int k;
        logic mb;
        k  = (j - 1) / 2;
        mb = b[k];
        push(0, run, 1, mb, ((mb && k < nn - 1) ? ADD : 7'd0) | ((mb && k == nn - 1) ? SUB : 7'd0) | BUSY, k);
      end else push(0, run, 1, 1, SHIFT | BUSY, (j - 2) / 2);
    end
  endtask
  task automatic chk(input string nm, input int idx, input logic [6:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %b want %b", nm, idx, act, exp);
    end
  endtask
  initial begin
    logic [6:0] act;
    logic [2:0] st;
    cur_sel = 0;
    push(1, 0, 1, 0, 7'd0, 0);
    push(1, 0, 1, 0, 7'd0, 0);
    push(0, 0, 1, 0, CLR_LD, 0);
    push(0, 0, 0, 0, 7'd0, 0);
    push(0, 1, 1, 0, 7'd0, 0);
    gen_run(8, 8'h07, 0, 17);
    push(0, 0, 0, 0, DONE, 0);
    push(0, 0, 0, 1, 7'd0, 0);
    push(0, 1, 0, 0, 7'd0, 0);
    gen_run(8, 8'h80, 0, 17);
    push(0, 0, 0, 0, DONE, 0);
    push(0, 0, 0, 0, 7'd0, 0);
    push(0, 1, 0, 0, 7'd0, 0);
    gen_run(8, 8'h55, 1, 17);
    push(0, 1, 0, 0, DONE, 0);
    push(0, 1, 0, 0, DONE, 0);
    push(0, 0, 0, 0, DONE, 0);
    push(0, 1, 0, 0, 7'd0, 0);
    gen_run(8, 8'h55, 0, 6);
    push(1, 0, 0, 1, 7'd0, 0);
    push(0, 0, 0, 1, 7'd0, 0);
    push(0, 0, 0, 1, 7'd0, 0);
    cur_sel = 1;
    push(1, 0, 1, 0, 7'd0, 0);
    push(0, 0, 1, 0, CLR_LD, 0);
    push(0, 1, 0, 0, 7'd0, 0);
    gen_run(4, 8'h0F, 0, 9);
    push(0, 0, 0, 0, DONE, 0);
    push(0, 0, 1, 0, CLR_LD, 0);
    foreach (tbl[i]) begin
      @(negedge clk);
      if (tbl[i].sel) begin
        {rst4, run4, clb4, m4} = {tbl[i].rst, tbl[i].run, tbl[i].clb, tbl[i].m};
        {rst8, run8, clb8, m8} = 4'b1000;
      end else begin
        {rst8, run8, clb8, m8} = {tbl[i].rst, tbl[i].run, tbl[i].clb, tbl[i].m};
        {rst4, run4, clb4, m4} = 4'b1000;
      end
      #1;
      act = tbl[i].sel ? {clr_ld4, clr_xa4, add4, sub4, shift4, busy4, done4}
                       : {clr_ld8, clr_xa8, add8, sub8, shift8, busy8, done8};
      st  = tbl[i].sel ? {1'b0, step4} : step8;
      chk("ctl", i, act, tbl[i].ctl);
      chk("step", i, {4'd0, st}, {4'd0, tbl[i].step});
      chk("onehot", i, {6'd0, $onehot0(act[6:2])}, 7'd1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
